grant_scheduler: RTL and testbench
==================================

GRANT_SCHEDULER -- requirements
Module: grant_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of requesters (fixed at 4 in this revision).
REQ-002 SHALL have parameter MAX_HOLD, default 8, meaning maximum grant tenure in cycles (legal range 2..255).
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req, input, 4, per-requester request level.
REQ-006 SHALL have port done, input, 4, per-requester release pulse.
REQ-007 SHALL have port gnt, output reg, 4, one-hot grant.
REQ-008 SHALL have port gnt_id, output reg, 2, binary index of the granted requester; valid only while busy=1.
REQ-009 SHALL have port busy, output reg, 1, high while any grant is held.
REQ-010 SHALL have port timeout, output reg, 1, one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Function
REQ-011 SHALL implement the states IDLE, GRANT and GAP, plus an 8-bit hold counter hcnt and a 2-bit rotating pointer ptr.
REQ-012 SHALL, in IDLE when req!=0, select the first set req bit at or after index ptr in the order ptr, ptr+1, ... mod 4, and at that edge set gnt to that one-hot value, set gnt_id to its index, set busy=1, clear hcnt to 0 and enter GRANT.
REQ-013 SHALL remain in IDLE with gnt=0 and busy=0 while req==0.
REQ-014 SHALL, in GRANT, increment hcnt by 1 on every edge on which the grant is not terminated.
REQ-015 SHALL terminate the grant at the edge on which any of the following holds: done[gnt_id]=1, req[gnt_id]=0, or hcnt==MAX_HOLD-1.
REQ-016 SHALL, on termination, clear gnt to 0 and busy to 0, set ptr to gnt_id+1 mod 4, and enter GAP.
REQ-017 SHALL assert timeout for exactly the cycle following a termination caused solely by hcnt==MAX_HOLD-1.
REQ-018 SHALL suppress timeout when done[gnt_id] or !req[gnt_id] coincides with hcnt==MAX_HOLD-1.
REQ-019 SHALL ignore done bits of non-granted requesters.
REQ-020 SHALL keep gnt=0 for exactly one cycle in GAP, then return to IDLE unconditionally.
REQ-021 SHALL therefore produce a minimum of two clock cycles between the deassertion of one grant and the assertion of the next.
REQ-022 SHALL never assert more than one gnt bit, and SHALL keep gnt and gnt_id stable for the whole tenure.
REQ-023 SHALL return to IDLE with all outputs cleared from any unencoded state value.
REQ-024 SHALL limit a tenure to at most MAX_HOLD cycles of gnt high.

Reset
REQ-025 SHALL, while reset=0, force the state to IDLE and set gnt=0, gnt_id=0, busy=0, timeout=0, hcnt=0 and ptr=0, regardless of clock.
REQ-026 SHALL, on reset assertion mid-grant, drop gnt asynchronously without a GAP cycle or a timeout pulse.
REQ-027 SHALL begin arbitration at the first rising edge after reset deasserts, with ptr=0.

Verification
REQ-028 Single request: after reset, hold req=4'b0100 and pulse done[2] on the 3rd grant cycle -> gnt=4'b0100 and gnt_id=2 for 3 cycles, then gnt=0 for 2 cycles with timeout=0.
REQ-029 Round robin: hold req=4'b1111 and pulse the owner's done after 1 grant cycle each time -> grant order is 0,1,2,3,0 with a 2-cycle gap between grants.
REQ-030 Timeout: hold req=4'b0001 with done=0 and MAX_HOLD=8 -> gnt[0] high for exactly 8 cycles, timeout high for 1 cycle, then gnt[0] re-granted 2 cycles after the drop.
REQ-031 Coincident release: apply done[gnt_id]=1 on the cycle where hcnt==MAX_HOLD-1 -> grant ends and timeout stays 0.
REQ-032 Foreign release and withdrawal: with requester 1 granted, pulse done[3] -> grant is unchanged; then deassert req[1] -> gnt clears at the next edge and ptr=2.
REQ-033 Reset mid-grant: with requester 2 granted, assert reset -> gnt=0 immediately; after release with req=4'b1100, requester 2 is granted first.

Source files
------------

// File: rtl/grant_scheduler_if.sv
// Request/grant bundle between the requesters and the grant scheduler.
// Latency: wires only, no storage.
// Backpressure: none; requesters hold req level until granted, release with done.
interface grant_scheduler_if;
   logic [3:0] req;
   logic [3:0] done;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
   logic       timeout;

   modport master (
      output req,
      output done,
      input  gnt,
      input  gnt_id,
      input  busy,
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      output gnt,
      output gnt_id,
      output busy,
      output timeout
   );
endinterface

// File: rtl/grant_scheduler.sv
// Round-robin single-owner grant scheduler with bounded tenure and a one-cycle release gap.
// Latency: grant asserts at the first edge after req seen in IDLE; release takes effect at the next edge.
// Backpressure: requesters hold req until granted; at least two idle cycles separate consecutive grants.
module grant_scheduler #(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic               clock,
   input  logic               reset,
   grant_scheduler_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t             state;
   logic [7:0]         hcnt;
   logic [1:0]         ptr;

   logic               pick_vld;
   logic [1:0]         pick_id;
   logic [1:0]         cand;
   logic [N_REQ-1:0]   pick_oh;
   logic               own_release;
   logic               at_limit;

   // Rotating priority search: walk from the farthest offset down so the
   // nearest set request at or after ptr is the one left standing.
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      cand     = '0;
      pick_oh  = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         cand = ptr + 2'(i);
         if (bus.req[cand]) begin
            pick_vld = 1'b1;
            pick_id  = cand;
         end
      end
      pick_oh[pick_id] = pick_vld;
   end

   // Termination causes for the current owner; other requesters' done bits are ignored.
   always_comb begin
      own_release = bus.done[bus.gnt_id] | ~bus.req[bus.gnt_id];
      at_limit    = (hcnt == 8'(MAX_HOLD - 1));
   end

   // Scheduler FSM with all outputs registered; reset drops the grant immediately.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         bus.gnt     <= '0;
         bus.gnt_id  <= '0;
         bus.busy    <= 1'b0;
         bus.timeout <= 1'b0;
         hcnt        <= '0;
         ptr         <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.timeout <= 1'b0;
               if (pick_vld) begin
                  bus.gnt    <= pick_oh;
                  bus.gnt_id <= pick_id;
                  bus.busy   <= 1'b1;
                  hcnt       <= '0;
                  state      <= GRANT;
               end
            end
            GRANT: begin
               if (own_release || at_limit) begin
                  bus.gnt     <= '0;
                  bus.busy    <= 1'b0;
                  ptr         <= bus.gnt_id + 2'd1;
                  // Only a pure tenure expiry is reported; a coincident release wins.
                  bus.timeout <= at_limit && !own_release;
                  state       <= GAP;
               end else begin
                  hcnt <= hcnt + 8'd1;
               end
            end
            GAP: begin
               bus.timeout <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               bus.gnt     <= '0;
               bus.gnt_id  <= '0;
               bus.busy    <= 1'b0;
               bus.timeout <= 1'b0;
               hcnt        <= '0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_grant_scheduler.sv
// Scenario bench for grant_scheduler: expected owners queued at stimulus time, checked at grant.
// Latency: samples 1 time unit after each rising edge.
// Backpressure: bounded waits on every grant.
module tb_grant_scheduler;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   exp_q[$];

   grant_scheduler_if bus();

   grant_scheduler #(.N_REQ(4), .MAX_HOLD(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   // Advance until busy rises or the budget runs out; gap counts idle samples seen.
   task automatic wait_grant(input int budget, output bit got, output int gap);
      got = 1'b0;
      gap = 0;
      while (!got && gap < budget) begin
         cycle();
         if (bus.busy) got = 1'b1;
         else gap++;
      end
   endtask

   task automatic apply_reset();
      bus.req  = 4'b0000;
      bus.done = 4'b0000;
      reset    = 1'b0;
      #1;
      cycle();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      bus.req  = 4'b0000;
      bus.done = 4'b0000;
      #1 reset = 1'b0;
      #1;
      checks++;
      if (bus.gnt !== 4'b0 || bus.gnt_id !== 2'd0 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
         failures++;
         $display("FAIL reset_async: gnt=%b id=%0d busy=%b to=%b want all zero", bus.gnt, bus.gnt_id, bus.busy, bus.timeout);
      end
      cycle();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle();
         checks++;
         if (bus.gnt !== 4'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req: gnt=%b busy=%b want 0000/0", bus.gnt, bus.busy);
         end
      end
   endtask

   task automatic test_single();
      bit got;
      int gap;
      int exp;
      apply_reset();
      bus.req = 4'b0100;
      exp_q.push_back(2);
      wait_grant(10, got, gap);
      exp = exp_q.pop_front();
      checks++;
      if (!got || gap !== 0) begin
         failures++;
         $display("FAIL single_latency: got=%b gap=%0d want 1/0", got, gap);
      end
      checks++;
      if (bus.gnt !== 4'(1 << exp) || bus.gnt_id !== 2'(exp)) begin
         failures++;
         $display("FAIL single_owner: gnt=%b id=%0d want id %0d", bus.gnt, bus.gnt_id, exp);
      end
      cycle();
      cycle();
      checks++;
      if (bus.gnt !== 4'b0100 || bus.gnt_id !== 2'd2) begin
         failures++;
         $display("FAIL single_hold: gnt=%b id=%0d want 0100/2", bus.gnt, bus.gnt_id);
      end
      bus.done = 4'b0100;
      cycle();
      bus.done = 4'b0000;
      checks++;
      if (bus.gnt !== 4'b0 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
         failures++;
         $display("FAIL single_gap1: gnt=%b busy=%b to=%b want 0000/0/0", bus.gnt, bus.busy, bus.timeout);
      end
      cycle();
      checks++;
      if (bus.gnt !== 4'b0 || bus.timeout !== 1'b0) begin
         failures++;
         $display("FAIL single_gap2: gnt=%b to=%b want 0000/0", bus.gnt, bus.timeout);
      end
      cycle();
      checks++;
      if (bus.gnt !== 4'b0100) begin
         failures++;
         $display("FAIL single_regrant: gnt=%b want 0100", bus.gnt);
      end
      bus.req = 4'b0000;
      cycle();
   endtask

   task automatic test_round_robin();
      bit got;
      int gap;
      int exp;
      apply_reset();
      bus.req = 4'b1111;
      exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(2);
      exp_q.push_back(3);
      exp_q.push_back(0);
      for (int g = 0; g < 5; g++) begin
         wait_grant(10, got, gap);
         exp = exp_q.pop_front();
         checks++;
         if (!got || bus.gnt_id !== 2'(exp) || bus.gnt !== 4'(1 << exp)) begin
            failures++;
            $display("FAIL rr_order[%0d]: got=%b gnt=%b id=%0d want id %0d", g, got, bus.gnt, bus.gnt_id, exp);
         end
         if (g > 0) begin
            checks++;
            if (gap + 1 !== 2) begin
               failures++;
               $display("FAIL rr_gap[%0d]: gap=%0d want 2", g, gap + 1);
            end
         end
         bus.done = 4'(1 << exp);
         cycle();
         bus.done = 4'b0000;
      end
      bus.req = 4'b0000;
      cycle();
      cycle();
   endtask

   task automatic test_timeout();
      bit got;
      int gap;
      int exp;
      int high;
      apply_reset();
      bus.req = 4'b0001;
      exp_q.push_back(0);
      wait_grant(10, got, gap);
      exp = exp_q.pop_front();
      checks++;
      if (!got || bus.gnt !== 4'(1 << exp)) begin
         failures++;
         $display("FAIL to_grant: got=%b gnt=%b want id %0d", got, bus.gnt, exp);
      end
      high = 1;
      while (bus.busy && high < 20) begin
         cycle();
         if (bus.busy) high++;
      end
      checks++;
      if (high !== 8) begin
         failures++;
         $display("FAIL to_tenure: %0d cycles want 8", high);
      end
      checks++;
      if (bus.timeout !== 1'b1) begin
         failures++;
         $display("FAIL to_pulse: timeout=%b want 1", bus.timeout);
      end
      cycle();
      checks++;
      if (bus.timeout !== 1'b0 || bus.gnt !== 4'b0) begin
         failures++;
         $display("FAIL to_pulse_end: timeout=%b gnt=%b want 0/0000", bus.timeout, bus.gnt);
      end
      cycle();
      checks++;
      if (bus.gnt !== 4'b0001) begin
         failures++;
         $display("FAIL to_regrant: gnt=%b want 0001", bus.gnt);
      end
      bus.req = 4'b0000;
      cycle();
      checks++;
      if (bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
         failures++;
         $display("FAIL to_withdraw: busy=%b to=%b want 0/0", bus.busy, bus.timeout);
      end
      cycle();
   endtask

   // Mode 0 releases with done, mode 1 withdraws req, both on the last allowed cycle.
   task automatic test_coincident();
      bit got;
      int gap;
      int exp;
      for (int mode = 0; mode < 2; mode++) begin
         apply_reset();
         bus.req = 4'b0001;
         exp_q.push_back(0);
         wait_grant(10, got, gap);
         exp = exp_q.pop_front();
         checks++;
         if (!got || bus.gnt_id !== 2'(exp)) begin
            failures++;
            $display("FAIL coin_grant[%0d]: got=%b id=%0d want %0d", mode, got, bus.gnt_id, exp);
         end
         repeat (7) cycle();
         checks++;
         if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL coin_cycle8[%0d]: busy=%b want 1", mode, bus.busy);
         end
         if (mode == 0) bus.done = 4'b0001;
         else bus.req = 4'b0000;
         cycle();
         bus.done = 4'b0000;
         bus.req  = 4'b0000;
         checks++;
         if (bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
            failures++;
            $display("FAIL coin_release[%0d]: busy=%b to=%b want 0/0", mode, bus.busy, bus.timeout);
         end
         cycle();
      end
   endtask

   task automatic test_foreign_release();
      bit got;
      int gap;
      int exp;
      apply_reset();
      bus.req = 4'b0010;
      exp_q.push_back(1);
      wait_grant(10, got, gap);
      exp = exp_q.pop_front();
      checks++;
      if (!got || bus.gnt_id !== 2'(exp)) begin
         failures++;
         $display("FAIL foreign_grant: got=%b id=%0d want %0d", got, bus.gnt_id, exp);
      end
      bus.req  = 4'b1010;
      bus.done = 4'b1000;
      cycle();
      bus.done = 4'b0000;
      checks++;
      if (bus.gnt !== 4'b0010 || bus.gnt_id !== 2'd1) begin
         failures++;
         $display("FAIL foreign_done: gnt=%b id=%0d want 0010/1", bus.gnt, bus.gnt_id);
      end
      bus.req = 4'b1000;
      cycle();
      checks++;
      if (bus.gnt !== 4'b0 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
         failures++;
         $display("FAIL withdraw: gnt=%b busy=%b to=%b want 0000/0/0", bus.gnt, bus.busy, bus.timeout);
      end
      // Requests on 1 and 2: only a pointer of 2 selects requester 2.
      bus.req = 4'b0110;
      exp_q.push_back(2);
      wait_grant(10, got, gap);
      exp = exp_q.pop_front();
      checks++;
      if (!got || bus.gnt_id !== 2'(exp) || gap + 1 !== 2) begin
         failures++;
         $display("FAIL ptr_after_withdraw: got=%b id=%0d gap=%0d want id %0d gap 2", got, bus.gnt_id, gap + 1, exp);
      end
      bus.req = 4'b0000;
      cycle();
      cycle();
   endtask

   task automatic test_reset_mid_grant();
      bit got;
      int gap;
      int exp;
      apply_reset();
      bus.req = 4'b0100;
      exp_q.push_back(2);
      wait_grant(10, got, gap);
      exp = exp_q.pop_front();
      checks++;
      if (!got || bus.gnt_id !== 2'(exp)) begin
         failures++;
         $display("FAIL midrst_grant: got=%b id=%0d want %0d", got, bus.gnt_id, exp);
      end
      cycle();
      #2 reset = 1'b0;
      #1;
      checks++;
      if (bus.gnt !== 4'b0 || bus.busy !== 1'b0 || bus.timeout !== 1'b0 || bus.gnt_id !== 2'd0) begin
         failures++;
         $display("FAIL midrst_async: gnt=%b id=%0d busy=%b to=%b want all zero", bus.gnt, bus.gnt_id, bus.busy, bus.timeout);
      end
      cycle();
      checks++;
      if (bus.gnt !== 4'b0 || bus.timeout !== 1'b0) begin
         failures++;
         $display("FAIL midrst_held: gnt=%b to=%b want 0000/0", bus.gnt, bus.timeout);
      end
      bus.req = 4'b1100;
      exp_q.push_back(2);
      reset = 1'b1;
      wait_grant(10, got, gap);
      exp = exp_q.pop_front();
      checks++;
      if (!got || gap !== 0 || bus.gnt !== 4'(1 << exp) || bus.timeout !== 1'b0) begin
         failures++;
         $display("FAIL midrst_restart: got=%b gap=%0d gnt=%b to=%b want id %0d gap 0", got, gap, bus.gnt, bus.timeout, exp);
      end
      bus.req = 4'b0000;
      cycle();
      cycle();
   endtask

   initial begin
      bus.req  = 4'b0000;
      bus.done = 4'b0000;
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_coincident();
      test_foreign_release();
      test_reset_mid_grant();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
